// File: rtl/cpu_defines.sv
// Shared register-file widths and the long-unit result payload.
package cpu_defines;

  localparam int unsigned REG_ADDR_WIDTH = 5;
  localparam int unsigned DATA_WIDTH     = 32;
  localparam int unsigned NUM_REGS       = 1 << REG_ADDR_WIDTH;
  localparam logic [REG_ADDR_WIDTH-1:0] ZERO_REG = 5'd0;

  typedef struct packed {
    logic [REG_ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0]     data;
  } long_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered count; head is the oldest stored entry.
module sync_fifo #(
  parameter int unsigned WIDTH = 37,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned COUNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0]   storage [DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [COUNT_W-1:0] count;
  logic               push_ok;
  logic               pop_ok;

  assign full    = (count == COUNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign head    = storage[rd_ptr];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + COUNT_W'(1);
        2'b01:   count <= count - COUNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) storage[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/register_write_arbiter.sv
// Shares the register-file write port between pipeline writeback and a
// buffered long-latency unit; tracks pending long-op destinations.
module register_write_arbiter
  import cpu_defines::*;
#(
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      pipe_write_enable,
  input  logic [REG_ADDR_WIDTH-1:0] pipe_write_address,
  input  logic [DATA_WIDTH-1:0]     pipe_write_data,
  input  logic                      long_valid,
  input  logic [REG_ADDR_WIDTH-1:0] long_address,
  input  logic [DATA_WIDTH-1:0]     long_data,
  output logic                      long_ready,
  input  logic                      mark_enable,
  input  logic [REG_ADDR_WIDTH-1:0] mark_address,
  input  logic [REG_ADDR_WIDTH-1:0] query_address_a,
  input  logic [REG_ADDR_WIDTH-1:0] query_address_b,
  output logic                      busy_a,
  output logic                      busy_b,
  output logic                      stall_request,
  output logic                      write_enable,
  output logic [REG_ADDR_WIDTH-1:0] write_address,
  output logic [DATA_WIDTH-1:0]     write_data
);

  localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

  long_entry_t         push_entry;
  long_entry_t         head_entry;
  logic                fifo_full;
  logic                fifo_empty;
  logic                fifo_push;
  logic                fifo_pop;
  logic                pipe_request;
  logic [STARVE_W-1:0] starve_count;
  logic [STARVE_W-1:0] starve_count_next;
  logic                stall_next;
  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] pending_next;

  assign push_entry = '{address: long_address, data: long_data};
  assign long_ready = reset && !fifo_full;
  assign fifo_push  = long_valid && long_ready && (long_address != ZERO_REG);

  sync_fifo #(
    .WIDTH($bits(long_entry_t)),
    .DEPTH(DEPTH)
  ) u_result_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (fifo_push),
    .push_data(push_entry),
    .pop      (fifo_pop),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head     (head_entry)
  );

  // Pipe has priority; a write to r0 is treated as no request.
  always_comb begin
    write_enable  = 1'b0;
    write_address = ZERO_REG;
    write_data    = '0;
    fifo_pop      = 1'b0;
    pipe_request  = pipe_write_enable && (pipe_write_address != ZERO_REG);
    if (reset) begin
      if (pipe_request) begin
        write_enable  = 1'b1;
        write_address = pipe_write_address;
        write_data    = pipe_write_data;
      end else if (!fifo_empty) begin
        write_enable  = 1'b1;
        write_address = head_entry.address;
        write_data    = head_entry.data;
        fifo_pop      = 1'b1;
      end
    end
  end

  // Mark is applied after the commit clear so a newer outstanding op wins.
  always_comb begin
    pending_next = pending;
    if (fifo_pop) pending_next[head_entry.address] = 1'b0;
    if (mark_enable && (mark_address != ZERO_REG)) pending_next[mark_address] = 1'b1;
  end

  always_comb begin
    starve_count_next = '0;
    stall_next        = stall_request;
    if (fifo_pop) begin
      stall_next = 1'b0;
    end else if (!fifo_empty && pipe_request) begin
      starve_count_next = (starve_count == STARVE_W'(STARVE_LIMIT)) ?
                          starve_count : starve_count + STARVE_W'(1);
      if (starve_count_next == STARVE_W'(STARVE_LIMIT)) stall_next = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      pending       <= '0;
      starve_count  <= '0;
      stall_request <= 1'b0;
    end else begin
      pending       <= pending_next;
      starve_count  <= starve_count_next;
      stall_request <= stall_next;
    end
  end

  assign busy_a = reset && (query_address_a != ZERO_REG) && pending[query_address_a];
  assign busy_b = reset && (query_address_b != ZERO_REG) && pending[query_address_b];

endmodule

// File: tb/tb_register_write_arbiter.sv
// Directed and randomized checks of the register write arbiter against a queue model.
module tb_register_write_arbiter;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned LIMIT = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        pipe_write_enable;
  logic [4:0]  pipe_write_address;
  logic [31:0] pipe_write_data;
  logic        long_valid;
  logic [4:0]  long_address;
  logic [31:0] long_data;
  logic        long_ready;
  logic        mark_enable;
  logic [4:0]  mark_address;
  logic [4:0]  query_address_a;
  logic [4:0]  query_address_b;
  logic        busy_a;
  logic        busy_b;
  logic        stall_request;
  logic        write_enable;
  logic [4:0]  write_address;
  logic [31:0] write_data;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [36:0] m_q[$];
  logic [31:0] m_pend;
  int          m_loss;
  logic        m_stall;

  register_write_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clock(clock), .reset(reset),
    .pipe_write_enable(pipe_write_enable), .pipe_write_address(pipe_write_address),
    .pipe_write_data(pipe_write_data),
    .long_valid(long_valid), .long_address(long_address), .long_data(long_data),
    .long_ready(long_ready),
    .mark_enable(mark_enable), .mark_address(mark_address),
    .query_address_a(query_address_a), .query_address_b(query_address_b),
    .busy_a(busy_a), .busy_b(busy_b), .stall_request(stall_request),
    .write_enable(write_enable), .write_address(write_address), .write_data(write_data)
  );

  always #5 clock = ~clock;

  // Advance the model by one rising edge using the inputs currently applied.
  task automatic model_step();
    logic        pipe_req;
    logic        commit;
    logic [36:0] head_e;
    int          pre;
    if (!reset) begin
      m_q.delete();
      m_pend  = '0;
      m_loss  = 0;
      m_stall = 1'b0;
      return;
    end
    pre      = m_q.size();
    pipe_req = pipe_write_enable && (pipe_write_address != 5'd0);
    commit   = !pipe_req && (pre > 0);
    head_e   = '0;
    if (commit) head_e = m_q.pop_front();
    if (long_valid && (pre < DEPTH) && (long_address != 5'd0)) m_q.push_back({long_address, long_data});
    if (commit) m_pend[head_e[36:32]] = 1'b0;
    if (mark_enable && (mark_address != 5'd0)) m_pend[mark_address] = 1'b1;
    if (commit) begin
      m_loss  = 0;
      m_stall = 1'b0;
    end else if ((pre > 0) && pipe_req) begin
      m_loss++;
      if (m_loss >= LIMIT) m_stall = 1'b1;
    end else begin
      m_loss = 0;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    pipe_write_enable = 1'b0; pipe_write_address = '0; pipe_write_data = '0;
    long_valid = 1'b0; long_address = '0; long_data = '0;
    mark_enable = 1'b0; mark_address = '0;
    query_address_a = '0; query_address_b = '0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle_inputs();
    query_address_a = 5'd3;
    tick(); tick();
    #1;
    total++; if (write_enable !== 1'b0) begin bad++; $display("FAIL reset_we got=%0b want=0", write_enable); end
    total++; if (long_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%0b want=0", long_ready); end
    total++; if (stall_request !== 1'b0) begin bad++; $display("FAIL reset_stall got=%0b want=0", stall_request); end
    reset = 1'b1;
    #1;
    total++; if (long_ready !== 1'b1) begin bad++; $display("FAIL post_reset_ready got=%0b want=1", long_ready); end
    total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL post_reset_busy got=%0b want=0", busy_a); end
  endtask

  task automatic test_pipe_write();
    idle_inputs();
    pipe_write_enable = 1'b1; pipe_write_address = 5'd3; pipe_write_data = 32'h11;
    query_address_a = 5'd3; query_address_b = 5'd5;
    #1;
    total++; if (write_enable !== 1'b1) begin bad++; $display("FAIL pipe_we got=%0b want=1", write_enable); end
    total++; if (write_address !== 5'd3) begin bad++; $display("FAIL pipe_addr got=%0d want=3", write_address); end
    total++; if (write_data !== 32'h11) begin bad++; $display("FAIL pipe_data got=%h want=11", write_data); end
    total++; if ({busy_a, busy_b} !== 2'b00) begin bad++; $display("FAIL pipe_busy got=%b want=00", {busy_a, busy_b}); end
    tick();
  endtask

  task automatic test_long_commit();
    idle_inputs();
    mark_enable = 1'b1; mark_address = 5'd5; query_address_a = 5'd5;
    #1;
    total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL mark_same_cycle_busy got=%0b want=0", busy_a); end
    tick();
    mark_enable = 1'b0;
    long_valid = 1'b1; long_address = 5'd5; long_data = 32'hAB;
    #1;
    total++; if (busy_a !== 1'b1) begin bad++; $display("FAIL marked_busy got=%0b want=1", busy_a); end
    total++; if (write_enable !== 1'b0) begin bad++; $display("FAIL accept_cycle_we got=%0b want=0", write_enable); end
    tick();
    long_valid = 1'b0;
    #1;
    total++; if ({write_enable, write_address, write_data} !== {1'b1, 5'd5, 32'hAB}) begin
      bad++; $display("FAIL long_commit got=%0b/%0d/%h want=1/5/ab", write_enable, write_address, write_data);
    end
    total++; if (busy_a !== 1'b1) begin bad++; $display("FAIL commit_cycle_busy got=%0b want=1", busy_a); end
    tick();
    #1;
    total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL after_commit_busy got=%0b want=0", busy_a); end
    total++; if (write_enable !== 1'b0) begin bad++; $display("FAIL after_commit_we got=%0b want=0", write_enable); end
  endtask

  task automatic test_starvation();
    logic [4:0] exp_addr;
    idle_inputs();
    for (int c = 0; c < 8; c++) begin
      pipe_write_enable  = (c < 5);
      pipe_write_address = 5'd9;
      pipe_write_data    = 32'h900 + 32'(c);
      long_valid         = (c < 7);
      long_address       = (c == 0) ? 5'd10 : (c == 1) ? 5'd11 : 5'd12;
      long_data          = 32'h100 + 32'(long_address);
      #1;
      total++; if (stall_request !== (c == 5)) begin bad++; $display("FAIL starve_stall c=%0d got=%0b want=%0b", c, stall_request, c == 5); end
      if (c >= 2 && c <= 5) begin
        total++; if (long_ready !== 1'b0) begin bad++; $display("FAIL full_ready c=%0d got=%0b want=0", c, long_ready); end
      end
      if (c == 6) begin
        total++; if (long_ready !== 1'b1) begin bad++; $display("FAIL third_accept_ready got=%0b want=1", long_ready); end
      end
      if (c >= 5) begin
        exp_addr = 5'(10 + c - 5);
        total++; if ({write_enable, write_address, write_data} !== {1'b1, exp_addr, 32'h100 + 32'(exp_addr)}) begin
          bad++; $display("FAIL starve_commit c=%0d got=%0b/%0d/%h want=1/%0d", c, write_enable, write_address, write_data, exp_addr);
        end
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_mark_same_edge();
    idle_inputs();
    mark_enable = 1'b1; mark_address = 5'd7;
    long_valid = 1'b1; long_address = 5'd7; long_data = 32'h77;
    tick();
    long_valid = 1'b0; query_address_b = 5'd7;
    #1;
    total++; if (write_address !== 5'd7 || write_enable !== 1'b1) begin bad++; $display("FAIL same_edge_commit got=%0b/%0d want=1/7", write_enable, write_address); end
    tick();
    mark_enable = 1'b0;
    #1;
    total++; if (busy_b !== 1'b1) begin bad++; $display("FAIL mark_wins got=%0b want=1", busy_b); end
  endtask

  task automatic test_r0();
    idle_inputs();
    long_valid = 1'b1; long_address = 5'd0; long_data = 32'hDEAD;
    #1;
    total++; if (long_ready !== 1'b1) begin bad++; $display("FAIL r0_ready got=%0b want=1", long_ready); end
    tick();
    long_valid = 1'b0;
    #1;
    total++; if (write_enable !== 1'b0) begin bad++; $display("FAIL r0_not_written got=%0b want=0", write_enable); end
    total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL r0_busy got=%0b want=0", busy_a); end
    long_valid = 1'b1; long_address = 5'd6; long_data = 32'h66;
    tick();
    long_valid = 1'b0;
    pipe_write_enable = 1'b1; pipe_write_address = 5'd0; pipe_write_data = 32'hBEEF;
    #1;
    total++; if ({write_enable, write_address, write_data} !== {1'b1, 5'd6, 32'h66}) begin
      bad++; $display("FAIL pipe_r0_yields got=%0b/%0d/%h want=1/6/66", write_enable, write_address, write_data);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    pipe_write_enable = 1'b1; pipe_write_address = 5'd1;
    for (int i = 0; i < 2; i++) begin
      long_valid = 1'b1; long_address = 5'(13 + i); long_data = 32'(i);
      mark_enable = 1'b1; mark_address = 5'(13 + i);
      tick();
    end
    idle_inputs();
    query_address_a = 5'd13; query_address_b = 5'd14;
    #1;
    total++; if ({busy_a, busy_b} !== 2'b11) begin bad++; $display("FAIL pre_reset_busy got=%b want=11", {busy_a, busy_b}); end
    reset = 1'b0;
    #1;
    total++; if ({write_enable, long_ready, busy_a, busy_b} !== 4'b0000) begin
      bad++; $display("FAIL in_reset_outputs got=%b want=0000", {write_enable, long_ready, busy_a, busy_b});
    end
    tick();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if ({write_enable, long_ready, busy_a, busy_b} !== 4'b0100) begin
        bad++; $display("FAIL after_reset i=%0d got=%b want=0100", i, {write_enable, long_ready, busy_a, busy_b});
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic        pipe_req;
    logic        exp_we;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;
    logic        exp_ready;
    logic        exp_ba;
    logic        exp_bb;
    for (int c = 0; c < 600; c++) begin
      reset              = ($urandom_range(0, 79) != 0);
      pipe_write_enable  = !m_stall && ($urandom_range(0, 99) < 60);
      pipe_write_address = 5'($urandom_range(0, 7));
      pipe_write_data    = $urandom;
      long_valid         = ($urandom_range(0, 99) < 50);
      long_address       = 5'($urandom_range(0, 7));
      long_data          = $urandom;
      mark_enable        = ($urandom_range(0, 99) < 30);
      mark_address       = 5'($urandom_range(0, 7));
      query_address_a    = 5'($urandom_range(0, 7));
      query_address_b    = 5'($urandom_range(0, 7));
      #1;
      pipe_req  = pipe_write_enable && (pipe_write_address != 5'd0);
      exp_we    = reset && (pipe_req || (m_q.size() > 0));
      exp_addr  = !exp_we ? 5'd0 : pipe_req ? pipe_write_address : m_q[0][36:32];
      exp_data  = !exp_we ? 32'd0 : pipe_req ? pipe_write_data : m_q[0][31:0];
      exp_ready = reset && (m_q.size() < DEPTH);
      exp_ba    = reset && (query_address_a != 5'd0) && m_pend[query_address_a];
      exp_bb    = reset && (query_address_b != 5'd0) && m_pend[query_address_b];
      total++; if ({write_enable, write_address, write_data} !== {exp_we, exp_addr, exp_data}) begin
        bad++; $display("FAIL rand_write c=%0d got=%0b/%0d/%h want=%0b/%0d/%h", c, write_enable, write_address, write_data, exp_we, exp_addr, exp_data);
      end
      total++; if (long_ready !== exp_ready) begin bad++; $display("FAIL rand_ready c=%0d got=%0b want=%0b", c, long_ready, exp_ready); end
      total++; if ({busy_a, busy_b} !== {exp_ba, exp_bb}) begin bad++; $display("FAIL rand_busy c=%0d got=%b want=%b", c, {busy_a, busy_b}, {exp_ba, exp_bb}); end
      total++; if (stall_request !== m_stall) begin bad++; $display("FAIL rand_stall c=%0d got=%0b want=%0b", c, stall_request, m_stall); end
      tick();
    end
    reset = 1'b1;
    idle_inputs();
  endtask

  initial begin
    m_pend  = '0;
    m_loss  = 0;
    m_stall = 1'b0;
    reset   = 1'b0;
    idle_inputs();
    @(posedge clock);
    #1;
    test_reset();
    test_pipe_write();
    test_long_commit();
    test_starvation();
    test_mark_same_edge();
    test_r0();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/register_write_arbiter.md
Name: register_write_arbiter

Overview:
- Shares the register file's single write port between two requesters.
- Requester 1: the in-order pipeline writeback, which is never back-pressured.
- Requester 2: a long-latency unit (divider / multi-cycle load), which uses a valid/ready handshake into a small FIFO.
- Also keeps a per-register pending scoreboard so decode can stall on registers whose long-latency result has not yet been committed.

Parameters:
- DEPTH, 2, long-unit result FIFO entries; power of two, ≥2.
- STARVE_LIMIT, 4, number of consecutive cycles the FIFO head may lose arbitration before stall_request is raised.

Ports:
- clock  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- pipe_write_enable  in  1  pipeline writeback valid.
- pipe_write_address  in  5  pipeline destination register.
- pipe_write_data  in  32  pipeline result.
- long_valid  in  1  long-unit result valid.
- long_address  in  5  long-unit destination register.
- long_data  in  32  long-unit result.
- long_ready  out  1  FIFO can accept; equals !full.
- mark_enable  in  1  decode issued a long op; mark its destination register pending.
- mark_address  in  5  register to mark.
- query_address_a  in  5  decode source register A.
- query_address_b  in  5  decode source register B.
- busy_a  out  1  query A register pending (combinational).
- busy_b  out  1  query B register pending (combinational).
- stall_request  out  1  registered; asks the pipeline to freeze writeback for one cycle.
- write_enable  out  1  to register file write port.
- write_address  out  5  to register file write port.
- write_data  out  32  to register file write port.

Behaviour:
- Reset (reset==0 at a rising edge):
  - FIFO emptied; pending[31:0] cleared; starve counter and stall_request cleared.
  - While reset==0, write_enable, long_ready, busy_a and busy_b are forced to 0.
  - A reset asserted mid-operation discards buffered results and clears pending bits without committing anything.
- Accept: a long-unit result enters the FIFO when long_valid && long_ready at the edge.
  - long_address==0 is handshaken (consumed) but not stored, and no pending bit changes.
- Arbitration is combinational in the same cycle, with zero added latency for pipe writes:
  - pipe_write_enable && pipe_write_address!=0: the pipe drives the write port.
  - Otherwise, FIFO non-empty: the FIFO head drives the port and is popped at the edge.
  - Otherwise: write_enable=0 and address/data=0.
  - A pipe write to r0 counts as no request, so the FIFO may use that cycle.
- Push and pop on the same edge are allowed.
  - Full FIFO with a pop that cycle: long_ready stays 0, because ready is computed from the registered count (no pass-through).
  - Empty FIFO with a push: the head is not visible until the next cycle.
- Starvation:
  - The counter increments each cycle the FIFO is non-empty and the pipe wins; it clears on any FIFO pop or when the FIFO is empty.
  - When the counter reaches STARVE_LIMIT, stall_request is set the next cycle.
  - Pipeline contract: pipe_write_enable==0 while stall_request==1.
  - stall_request clears the cycle after the FIFO head commits.
- Scoreboard:
  - mark_enable with mark_address!=0 sets pending[mark_address] at the edge.
  - A FIFO commit clears pending[write_address] at the edge.
  - Mark and clear of the same register on the same edge: mark wins, since a newer op is outstanding.
  - busy_x = pending[query_address_x], with r0 always 0; queries see the registered state only.
- Pipe writes never touch the scoreboard.

Decomposition:
- Shared package (cpu_defines): REG_ADDR_WIDTH=5, DATA_WIDTH=32, ZERO_REG=5'd0.
- One sub-module: sync_fifo (DATA_WIDTH+5 bits wide, DEPTH entries, push/pop/full/empty/head).
- Arbiter, starve counter and scoreboard stay in the top module.

Test Plan:
- Reset, then pipe write r3=0x11 → same-cycle write_enable=1, address=3, data=0x11; busy all 0.
- mark r5, long result r5=0xAB with pipe idle → busy_a(r5)=1 until the commit cycle; commit of 5/0xAB the cycle after accept; busy_a=0 the following cycle.
- Three long results with DEPTH=2 while the pipe writes every cycle:
  - long_ready=0 after two accepts.
  - stall_request=1 after 4 losses.
  - Freeze pipe → head commits, stall_request drops the next cycle, and the third result is accepted.
- Same edge: FIFO commits r7 while mark r7 → pending[7] stays 1.
- Long result to r0 → accepted, never written, no busy bit; pipe write to r0 while FIFO non-empty → FIFO head commits.
- reset=0 with 2 entries buffered and pending bits set → after reset, no writes occur, busy=0, long_ready=1.
